// File: rtl/pixie_pkg.sv
// Pixie display DMA fetch: shared constants,
// CPU state codes and a small range helper.
package pixie_pkg;

  localparam int LINES_PER_FRAME = 262;
  localparam int DMA_FIRST_LINE  = 80;
  localparam int DMA_LAST_LINE   = 207;
  localparam int MC_PER_LINE     = 14;
  localparam int LINE_BYTES      = 8;
  localparam int LINE_W          = 9;

  typedef enum logic [1:0] {
    SC_FETCH = 2'b00,
    SC_EXEC  = 2'b01,
    SC_DMA   = 2'b10,
    SC_INT   = 2'b11
  } sc_e;

  function automatic logic in_rng(
    input logic [LINE_W-1:0] v,
    input int                lo,
    input int                hi
  );
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/pixie_line_buffer.sv
// Double-buffered 8-byte line store: one bank
// fills from DMA while the other is read out.
module pixie_line_buffer
  import pixie_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_idx,
  input  logic [7:0] wr_data,
  input  logic       swap,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem_q [2][LINE_BYTES];
  logic [7:0] mem_d [2][LINE_BYTES];
  logic       disp_sel_q;
  logic       disp_sel_d;
  logic       fill_sel;
  logic [7:0] rd_data_q;
  logic [7:0] rd_data_d;

  // Fill-bank writes, bank swap with scrub of
  // the bank that becomes the next fill bank.
  always_comb begin
    mem_d      = mem_q;
    disp_sel_d = disp_sel_q;
    fill_sel   = ~disp_sel_q;
    rd_data_d  = mem_q[disp_sel_q][rd_addr];
    if (wr_en) begin
      mem_d[fill_sel][wr_idx] = wr_data;
    end
    if (swap) begin
      disp_sel_d        = fill_sel;
      mem_d[disp_sel_q] = '{default: '0};
    end
  end

  // Storage, bank select and read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '{default: '0};
      disp_sel_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      mem_q      <= mem_d;
      disp_sel_q <= disp_sel_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/pixie_dma_fetch.sv
// Pixie display DMA fetch: line/mc timing,
// DMAO request, byte capture, INT/EFx flags.
module pixie_dma_fetch
  import pixie_pkg::sc_e;
  import pixie_pkg::SC_DMA;
  import pixie_pkg::in_rng;
#(
  parameter int LINES_PER_FRAME = pixie_pkg::LINES_PER_FRAME,
  parameter int DMA_FIRST_LINE  = pixie_pkg::DMA_FIRST_LINE,
  parameter int DMA_LAST_LINE   = pixie_pkg::DMA_LAST_LINE,
  parameter int MC_PER_LINE     = pixie_pkg::MC_PER_LINE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_enable,
  input  logic       TPA,
  input  logic       TPB,
  input  logic [1:0] SC,
  input  logic       disp_on,
  input  logic       disp_off,
  input  logic [7:0] data_in,
  input  logic [2:0] rd_addr,
  output logic       DMAO,
  output logic       INT,
  output logic       EFx,
  output logic [7:0] rd_data,
  output logic       line_done,
  output logic       line_short,
  output logic       dma_overrun,
  output logic [8:0] line_num
);

  localparam int MCW = $clog2(MC_PER_LINE);

  logic [1:0]     rsync_q, rsync_d;
  logic           rst_n;
  logic [MCW-1:0] mc_q, mc_d;
  logic [8:0]     line_q, line_d;
  logic [2:0]     idx_q, idx_d;
  logic           disp_en_q, disp_en_d;
  logic           active_q, active_d;
  logic           full_q, full_d;
  logic           dmao_q, dmao_d;
  logic           int_q, int_d;
  logic           efx_q, efx_d;
  logic           done_q, done_d;
  logic           short_q, short_d;
  logic           ovr_q, ovr_d;

  logic tick, strobe, mc_last, wrap;
  logic dma_line, win, cap;
  logic full_now, short_now, swap;

  // Reset asserts at once, releases on clk.
  always_comb begin
    rsync_d = {rsync_q[0], 1'b1};
  end

  // Reset synchronizer flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rsync_q <= 2'b00;
    else        rsync_q <= rsync_d;
  end

  assign rst_n = rsync_q[1];

  // Line timing, capture window and flags.
  always_comb begin
    tick     = clk_enable & TPA;
    strobe   = clk_enable & TPB &
               (sc_e'(SC) == SC_DMA);
    mc_last  = (mc_q == MCW'(MC_PER_LINE - 1));
    wrap     = tick & mc_last;
    dma_line = in_rng(line_q, DMA_FIRST_LINE,
                      DMA_LAST_LINE);
    win      = active_q & dma_line & ~full_q &
               (mc_q >= MCW'(2));
    cap       = strobe & win;
    full_now  = cap & (idx_q == 3'd7);
    short_now = wrap & active_q & dma_line &
                ~full_q & ~full_now;
    swap      = full_now | short_now;

    mc_d      = mc_q;
    line_d    = line_q;
    idx_d     = idx_q;
    disp_en_d = disp_en_q;
    active_d  = active_q;
    full_d    = full_q;
    short_d   = short_q;

    if (tick) begin
      mc_d = mc_last ? '0 : mc_q + 1'b1;
    end
    if (wrap) begin
      line_d = (line_q == 9'(LINES_PER_FRAME - 1))
               ? 9'd0 : line_q + 9'd1;
    end
    if (clk_enable) begin
      if (disp_off)     disp_en_d = 1'b0;
      else if (disp_on) disp_en_d = 1'b1;
    end
    if (mc_q == '0) begin
      active_d = disp_en_q;
    end
    if (swap || wrap) idx_d = 3'd0;
    else if (cap)     idx_d = idx_q + 3'd1;
    if (wrap)          full_d = 1'b0;
    else if (full_now) full_d = 1'b1;
    if (short_now)     short_d = 1'b1;
    else if (full_now) short_d = 1'b0;

    dmao_d = ~win;
    done_d = swap;
    ovr_d  = ovr_q | (strobe & ~win);
    int_d  = disp_en_q &
             in_rng(line_q, DMA_FIRST_LINE - 2,
                    DMA_FIRST_LINE - 1);
    efx_d  = in_rng(line_q, DMA_FIRST_LINE - 4,
                    DMA_FIRST_LINE - 1) |
             in_rng(line_q, DMA_LAST_LINE - 3,
                    DMA_LAST_LINE);
  end

  // Timing, capture and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_q      <= '0;
      line_q    <= '0;
      idx_q     <= '0;
      disp_en_q <= 1'b0;
      active_q  <= 1'b0;
      full_q    <= 1'b0;
      dmao_q    <= 1'b1;
      int_q     <= 1'b0;
      efx_q     <= 1'b0;
      done_q    <= 1'b0;
      short_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      mc_q      <= mc_d;
      line_q    <= line_d;
      idx_q     <= idx_d;
      disp_en_q <= disp_en_d;
      active_q  <= active_d;
      full_q    <= full_d;
      dmao_q    <= dmao_d;
      int_q     <= int_d;
      efx_q     <= efx_d;
      done_q    <= done_d;
      short_q   <= short_d;
      ovr_q     <= ovr_d;
    end
  end

  pixie_line_buffer u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cap),
    .wr_idx  (idx_q),
    .wr_data (data_in),
    .swap    (swap),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign DMAO        = dmao_q;
  assign INT         = int_q;
  assign EFx         = efx_q;
  assign line_done   = done_q;
  assign line_short  = short_q;
  assign dma_overrun = ovr_q;
  assign line_num    = line_q;

endmodule

// File: tb/tb_pixie_dma_fetch.sv
// Directed bench for pixie_dma_fetch: full and
// short lines, overrun, display timing, reset.
module tb_pixie_dma_fetch;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_enable = 1'b0;
  logic       TPA = 1'b0;
  logic       TPB = 1'b0;
  logic [1:0] SC = 2'b00;
  logic       disp_on = 1'b0;
  logic       disp_off = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [2:0] rd_addr = 3'd0;
  logic       DMAO, INT, EFx;
  logic [7:0] rd_data;
  logic       line_done, line_short, dma_overrun;
  logic [8:0] line_num;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int b_mc = 0;
  int b_line = 0;
  int d0 = 0;

  pixie_dma_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .TPA         (TPA),
    .TPB         (TPB),
    .SC          (SC),
    .disp_on     (disp_on),
    .disp_off    (disp_off),
    .data_in     (data_in),
    .rd_addr     (rd_addr),
    .DMAO        (DMAO),
    .INT         (INT),
    .EFx         (EFx),
    .rd_data     (rd_data),
    .line_done   (line_done),
    .line_short  (line_short),
    .dma_overrun (dma_overrun),
    .line_num    (line_num)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (line_done === 1'b1) done_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic ce, input logic a,
                     input logic b, input logic on,
                     input logic off,
                     input logic [1:0] sc,
                     input logic [7:0] d);
    @(negedge clk);
    clk_enable = ce;
    TPA = a;
    TPB = b;
    disp_on = on;
    disp_off = off;
    SC = sc;
    data_in = d;
    @(posedge clk);
    #1;
    clk_enable = 1'b0;
    TPA = 1'b0;
    TPB = 1'b0;
    disp_on = 1'b0;
    disp_off = 1'b0;
    SC = 2'b00;
    data_in = 8'h00;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
  endtask

  task automatic tick();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    if (b_mc == 13) begin
      b_mc = 0;
      b_line = (b_line == 261) ? 0 : b_line + 1;
    end else begin
      b_mc++;
    end
  endtask

  task automatic strobe(input logic [7:0] d);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, d);
  endtask

  task automatic goto(input int l, input int m);
    int n;
    n = 0;
    while (!(b_line == l && b_mc == m) && n < 8000) begin
      tick();
      n++;
    end
    if (n >= 8000) begin
      failures++;
      $error("FAIL goto_bound line=%0d mc=%0d", l, m);
    end
    chk("goto_line", line_num, l);
  endtask

  initial begin
    // power-up reset, then asynchronous assertion
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dmao", DMAO, 1);
    chk("rst_int", INT, 0);
    chk("rst_efx", EFx, 0);
    chk("rst_done", line_done, 0);
    chk("rst_short", line_short, 0);
    chk("rst_ovr", dma_overrun, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_line", line_num, 0);
    @(negedge clk) reset = 1'b1;
    repeat (3) idle();

    // TPA without clk_enable must not count
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00);

    // full line 80: 8 strobes 0x01..0x08
    goto(80, 0);
    tick();
    idle();
    chk("dmao_mc1", DMAO, 1);
    tick();
    idle();
    chk("dmao_mc2", DMAO, 0);
    d0 = done_cnt;
    for (int i = 1; i <= 8; i++) strobe(8'(i));
    chk("done_8th", line_done, 1);
    chk("dmao_8th", DMAO, 0);
    idle();
    chk("dmao_after", DMAO, 1);
    chk("done_after", line_done, 0);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      idle();
      chk("rd_full", rd_data, i + 1);
    end
    chk("done_once", done_cnt - d0, 1);
    chk("short_full", line_short, 0);
    chk("ovr_pre", dma_overrun, 0);

    // 9th strobe on the completed line
    strobe(8'h99);
    chk("ovr_9th", dma_overrun, 1);
    rd_addr = 3'd0;
    idle();
    chk("rd_keep0", rd_data, 8'h01);
    rd_addr = 3'd7;
    idle();
    chk("rd_keep7", rd_data, 8'h08);

    // display off, then on mid-line 100
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00);
    goto(100, 5);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00);
    while (b_line == 100) begin
      tick();
      chk("dmao_l100", DMAO, 1);
    end
    tick();
    tick();
    idle();
    chk("dmao_l101", DMAO, 0);
    chk("short_pre", line_short, 0);
    d0 = done_cnt;
    goto(102, 0);
    chk("done_l101", line_done, 1);
    chk("short_l101", line_short, 1);
    idle();
    chk("done_l101_n", done_cnt - d0, 1);

    // free-run to line 80 of the next frame
    begin
      int n;
      bit wr;
      n = 0;
      wr = 1'b0;
      while (!(wr && b_line == 80 && b_mc == 0)
             && n < 8000) begin
        tick();
        n++;
        if (b_line == 0 && b_mc == 0) begin
          wr = 1'b1;
          chk("wrap", line_num, 0);
        end
        if (b_mc == 1) begin
          idle();
          chk("int", INT,
              (b_line == 78 || b_line == 79));
          chk("efx", EFx,
              (b_line >= 76 && b_line <= 79) ||
              (b_line >= 204 && b_line <= 207));
          chk("line", line_num, b_line);
        end
      end
      if (n >= 8000) begin
        failures++;
        $error("FAIL frame_bound n=%0d", n);
      end
    end

    // short line 80: five strobes of 0xAA
    tick();
    tick();
    for (int i = 0; i < 5; i++) strobe(8'hAA);
    d0 = done_cnt;
    goto(81, 0);
    chk("done_short", line_done, 1);
    chk("short_flag", line_short, 1);
    idle();
    chk("done_short_n", done_cnt - d0, 1);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      idle();
      chk("rd_short", rd_data, (i < 5) ? 8'hAA : 8'h00);
    end
    rd_addr = 3'd0;
    idle();

    // reset at mc 7 of line 120, mid-capture
    goto(120, 2);
    strobe(8'h11);
    strobe(8'h22);
    goto(120, 7);
    chk("pre_rst_dmao", DMAO, 0);
    d0 = done_cnt;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mrst_dmao", DMAO, 1);
    chk("mrst_line", line_num, 0);
    chk("mrst_short", line_short, 0);
    chk("mrst_ovr", dma_overrun, 0);
    chk("mrst_rd", rd_data, 0);
    chk("mrst_done", line_done, 0);
    chk("mrst_efx", EFx, 0);
    repeat (4) idle();
    @(negedge clk) reset = 1'b1;
    b_mc = 0;
    b_line = 0;
    repeat (4) idle();
    chk("mrst_nodone", done_cnt - d0, 0);

    // DMA strobe on non-display line 50
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00);
    goto(50, 4);
    chk("ovr_l50_pre", dma_overrun, 0);
    strobe(8'h5A);
    chk("ovr_l50", dma_overrun, 1);
    rd_addr = 3'd0;
    idle();
    chk("rd_l50", rd_data, 0);
    chk("dmao_l50", DMAO, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
